sync_fifo_dp: RTL and testbench

Parametrised synchronous FIFO built on the team's dual-port RAM. It adds read/write pointers, occupancy tracking, full/empty and programmable almost-full/almost-empty flags, a registered read-data-valid strobe, and overflow/underflow error pulses. It is the generalised successor to the fixed 8x16 dual-port RAM wrapper. It sits between producer and consumer blocks in the same clock domain.

---
 rtl/sync_fifo_pkg.sv | 37 +++
 rtl/dual_port_ram_16x8.sv | 33 +++
 rtl/sync_fifo_dp.sv | 107 ++++++++++
 tb/tb_sync_fifo_dp.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared helpers and defaults for the synchronous dual-port FIFO.
// Latency: n/a (elaboration-time constants and functions only).
// Backpressure: n/a.
package sync_fifo_pkg;

    localparam int def_width    = 16;
    localparam int def_depth    = 8;
    localparam int def_addr_bus = 3;
    localparam int def_af_thr   = 6;
    localparam int def_ae_thr   = 2;

    // Ceiling log2, evaluated at elaboration.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // True when value is a power of two and at least 2.
    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    // Legal FIFO shape: power-of-two depth, matching address width and
    // ordered almost-empty/almost-full thresholds.
    function automatic bit cfg_ok(input int depth, input int addr_bus,
                                  input int ae_thr, input int af_thr);
        return is_pow2(depth) && (addr_bus == clog2(depth)) &&
               (ae_thr < af_thr) && (af_thr <= depth);
    endfunction

endpackage

// File: rtl/dual_port_ram_16x8.sv
// Simple dual-port RAM: one synchronous write port, one combinational read port.
// Latency: write lands at the clock edge; read data is valid in the same cycle as the address.
// Backpressure: none; the owner decides when to write or read. Reads see pre-edge contents.
module dual_port_ram_16x8 #(
    parameter int width    = 16,
    parameter int depth    = 8,
    parameter int addr_bus = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic                re,
    input  logic [addr_bus-1:0] wr_addr,
    input  logic [addr_bus-1:0] rd_addr,
    input  logic [width-1:0]    d_in,
    output logic [width-1:0]    d_out
);

    logic [width-1:0] mem [depth];

    // Storage is never cleared; reset only blocks writes while held low.
    always_ff @(posedge clk) begin
        if (rst && we) begin
            mem[wr_addr] <= d_in;
        end
    end

    // Combinational read so a same-edge write to the same address returns the old word.
    always_comb begin
        d_out = re ? mem[rd_addr] : '0;
    end

endmodule

// File: rtl/sync_fifo_dp.sv
// Synchronous FIFO over a dual-port RAM with occupancy, almost flags and error pulses.
// Latency: 1 cycle from accepted read to d_out/d_valid; write readable the next cycle.
// Backpressure: writes refused when full (unless a read frees the slot), reads refused when empty; refusals pulse overflow/underflow.
module sync_fifo_dp
    import sync_fifo_pkg::*;
#(
    parameter int width    = def_width,
    parameter int depth    = def_depth,
    parameter int addr_bus = def_addr_bus,
    parameter int af_thr   = def_af_thr,
    parameter int ae_thr   = def_ae_thr
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [width-1:0]    d_in,
    input  logic                we,
    input  logic                re,
    output logic [width-1:0]    d_out,
    output logic                d_valid,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [addr_bus:0]   count,
    output logic                overflow,
    output logic                underflow
);

    if (!cfg_ok(depth, addr_bus, ae_thr, af_thr)) begin : g_bad_cfg
        $error("sync_fifo_dp: illegal depth/addr_bus/threshold combination");
    end

    localparam logic [addr_bus:0]   cnt_depth = (addr_bus + 1)'(depth);
    localparam logic [addr_bus:0]   cnt_af    = (addr_bus + 1)'(af_thr);
    localparam logic [addr_bus:0]   cnt_ae    = (addr_bus + 1)'(ae_thr);
    localparam logic [addr_bus:0]   cnt_one   = (addr_bus + 1)'(1);
    localparam logic [addr_bus-1:0] ptr_one   = addr_bus'(1);

    logic [addr_bus-1:0] wr_ptr;
    logic [addr_bus-1:0] rd_ptr;
    logic                wr_ok;
    logic                rd_ok;
    logic [addr_bus:0]   count_nxt;
    logic [width-1:0]    ram_rd;

    // Accept decisions use the registered flags; a full FIFO still takes a
    // write when a read frees the oldest slot in the same cycle.
    always_comb begin
        rd_ok     = re && !empty;
        wr_ok     = we && (!full || re);
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + cnt_one;
            2'b01:   count_nxt = count - cnt_one;
            default: count_nxt = count;
        endcase
    end

    dual_port_ram_16x8 #(
        .width    (width),
        .depth    (depth),
        .addr_bus (addr_bus)
    ) u_ram (
        .clk     (clk),
        .rst     (1'b1),
        .we      (wr_ok),
        .re      (rd_ok),
        .wr_addr (wr_ptr),
        .rd_addr (rd_ptr),
        .d_in    (d_in),
        .d_out   (ram_rd)
    );

    // Pointers, occupancy, flags (from next count), read-data register and error pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            d_out        <= '0;
            d_valid      <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ptr_one;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ptr_one;
                d_out  <= ram_rd;
            end
            count        <= count_nxt;
            full         <= (count_nxt == cnt_depth);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= cnt_af);
            almost_empty <= (count_nxt <= cnt_ae);
            d_valid      <= rd_ok;
            overflow     <= we && !wr_ok;
            underflow    <= re && !rd_ok;
        end
    end

endmodule

// File: tb/tb_sync_fifo_dp.sv
// Self-checking bench for sync_fifo_dp with a queue model and output scoreboard.
// Latency: checks one cycle after each driven edge.
// Backpressure: model mirrors accept rules to predict overflow/underflow.
module tb_sync_fifo_dp;

    localparam int width    = 16;
    localparam int depth    = 8;
    localparam int addr_bus = 3;
    localparam int af_thr   = 6;
    localparam int ae_thr   = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [width-1:0]    d_in = '0;
    logic                we = 1'b0;
    logic                re = 1'b0;
    logic [width-1:0]    d_out;
    logic                d_valid;
    logic                full;
    logic                empty;
    logic                almost_full;
    logic                almost_empty;
    logic [addr_bus:0]   count;
    logic                overflow;
    logic                underflow;

    int checks = 0;
    int errors = 0;

    logic [width-1:0] model_q[$];
    logic [width-1:0] exp_q[$];
    logic [width-1:0] last_dout = '0;

    always #5 clk = ~clk;

    sync_fifo_dp #(
        .width    (width),
        .depth    (depth),
        .addr_bus (addr_bus),
        .af_thr   (af_thr),
        .ae_thr   (ae_thr)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .d_in         (d_in),
        .we           (we),
        .re           (re),
        .d_out        (d_out),
        .d_valid      (d_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus followed by a full comparison against the model.
    task automatic cyc(input logic w, input logic r, input logic [width-1:0] d);
        int  sz;
        bit  m_full, m_empty, m_wr, m_rd, m_ov, m_un;
        sz      = model_q.size();
        m_full  = (sz == depth);
        m_empty = (sz == 0);
        m_rd    = r && !m_empty;
        m_wr    = w && (!m_full || r);
        m_ov    = w && !m_wr;
        m_un    = r && !m_rd;
        if (m_rd) exp_q.push_back(model_q.pop_front());
        if (m_wr) model_q.push_back(d);
        sz = model_q.size();

        we   = w;
        re   = r;
        d_in = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;

        chk("count", 32'(count), 32'(sz));
        chk("full", 32'(full), 32'(sz == depth));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("almost_full", 32'(almost_full), 32'(sz >= af_thr));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= ae_thr));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
        chk("d_valid", 32'(d_valid), 32'(m_rd));
        if (d_valid) begin
            if (exp_q.size() == 0) begin
                chk("d_out_unexpected", 32'(d_out), 32'hDEAD_BEEF);
            end else begin
                last_dout = exp_q.pop_front();
                chk("d_out", 32'(d_out), 32'(last_dout));
            end
        end else begin
            chk("d_out_hold", 32'(d_out), 32'(last_dout));
        end
    endtask

    // Hold reset for one edge with requests asserted; they must be ignored.
    task automatic do_reset();
        rst  = 1'b0;
        we   = 1'b1;
        re   = 1'b1;
        d_in = 16'h7777;
        @(posedge clk);
        #1;
        we  = 1'b0;
        re  = 1'b0;
        rst = 1'b1;
        model_q.delete();
        exp_q.delete();
        last_dout = '0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_d_out", 32'(d_out), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [width-1:0] v;
        @(posedge clk);
        #1;
        do_reset();
        cyc(1'b0, 1'b0, '0);

        // Fill: count 1..8, almost_full at 6, full at 8.
        for (int i = 0; i < depth; i++) cyc(1'b1, 1'b0, 16'hA000 + 16'(i));

        // Overflow: write while full is refused.
        cyc(1'b1, 1'b0, 16'hFFFF);
        cyc(1'b0, 1'b0, '0);

        // Full with simultaneous write and read: oldest word out, count stays 8.
        cyc(1'b1, 1'b1, 16'hBEEF);

        // Drain everything, then one extra read underflows.
        for (int i = 0; i < depth; i++) cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);

        // Empty with write and read together: write wins, read refused.
        cyc(1'b1, 1'b1, 16'h1234);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);

        // Wrap-around: hold around 3 entries while 20 write/read pairs stream through.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h3000 + 16'(i));
        for (int i = 0; i < 20; i++) begin
            v = 16'($urandom_range(0, 16'hFFFE));
            cyc(1'b1, 1'b0, v);
            cyc(1'b0, 1'b1, '0);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);

        // Mid-operation reset at count 5 discards contents.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'hC000 + 16'(i));
        do_reset();
        cyc(1'b1, 1'b0, 16'h5555);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
